aq_ejpeg_zigzag: RTL and testbench
==================================

# aq_ejpeg_zigzag

Zigzag scan buffer for the JPEG encoder path. Sits between the quantizer, which writes each 8x8 block in natural raster order two coefficients per cycle, and the Huffman encoder, which reads one coefficient per cycle in zigzag order. Four block banks decouple the two sides. Each committed block carries a colour tag and the zigzag index of its last non-zero coefficient, which the encoder uses for EOB placement.

## Interface
- No parameters; data width 16, 4 banks of 64 coefficients, fixed.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- DataInit  in  1  pulse; flush all banks and return to empty
- DataInEnable  in  1  write strobe for a coefficient pair
- DataInAddress  in  5  pair index w: natural coefficients 2w (A) and 2w+1 (B)
- DataInA  in  16  coefficient at natural index 2w, signed
- DataInB  in  16  coefficient at natural index 2w+1, signed
- DataInColor  in  3  colour tag, sampled on DataInEnd
- DataInEnd  in  1  pulse; commit the block being written
- DataInIdle  out  1  high when a free bank exists; writes are accepted only while high
- DataOutEnable  out  1  high when at least one committed block exists
- DataOutRead  in  1  read strobe
- DataOutAddress  in  6  zigzag index k to read
- DataOut  out  16  coefficient at zigzag index k of the read bank
- DataOutColor  out  3  colour tag of the read bank
- DataOutLast  out  6  zigzag index of the last non-zero coefficient in the read bank
- DataOutNonZero  out  1  read bank holds at least one non-zero coefficient

## Operation
- Storage: 128 x 32 memory, word {B,A} at {WriteBank, w}. Read address {ReadBank, n[5:1]}, where n = ZZ(k) is the standard JPEG zigzag-to-natural map. Examples: k0→0, 1→1, 2→8, 3→16, 4→9, 5→2, 28→7, 35→56, 63→63. The half is selected by the registered n[0].
- Count: BankCount is 3 bits, 0..4 committed banks.
- Commit: the cycle where DataInEnd=1 and DataInIdle=1.
  - BankColor[WriteBank] ← DataInColor.
  - BankLast and BankNonZero ← the merged tracker value.
  - WriteBank increments, wrapping 3→0.
- Release: the cycle where DataOutRead=1, DataOutAddress=63 and DataOutEnable=1. ReadBank increments, wrapping 3→0.
- States:
  - S_IDLE: count 0.
  - S_VALID: count 1..3.
  - S_FULL: count 4.
  - S_INIT: one cycle.
- Transitions:
  - Commit only: count+1. A commit that takes the count to 4 goes to S_FULL.
  - Release only: count−1. A release that takes the count to 0 goes to S_IDLE.
  - Commit and release in the same cycle: count unchanged, state unchanged, both bank pointers advance.
  - DataInit in any state: go to S_INIT for one cycle. There, clear the count, both bank pointers and the tracker, then go to S_IDLE. DataInit has priority over commit and release.
- Full: while DataInIdle=0, DataInEnable and DataInEnd are ignored. No memory write, no tracker update.
- Empty: while DataOutEnable=0, the read side is ignored; DataOut still follows the memory contents.
- Last-non-zero tracker, running for the write bank:
  - On each accepted write, candidate = max(current, IZZ(2w) if A≠0, IZZ(2w+1) if B≠0). IZZ is the inverse zigzag map.
  - A flag is set when any write is non-zero.
  - A write in the same cycle as DataInEnd is included in the committed value.
  - The tracker clears after a commit and in S_INIT.
  - A block with no non-zero coefficient commits Last=0, NonZero=0.
- Unwritten pairs hold stale data; the quantizer writes all 32 pairs per block.
- DataInIdle = state ≠ S_FULL and state ≠ S_INIT.
- DataOutEnable = state ∈ {S_VALID, S_FULL}.

## Timing
- Reset values:
  - State=S_IDLE; BankCount=0; WriteBank=0; ReadBank=0.
  - BankColor, BankLast and BankNonZero = 0.
  - Output register = 0, so DataOut=0.
  - DataInIdle=1, DataOutEnable=0, DataOutColor=0, DataOutLast=0, DataOutNonZero=0.
- Write: the memory is updated on the clock edge where the write is accepted. A bank is readable in the cycle after its commit edge.
- Read latency is 1: DataOut is valid on the cycle after DataOutRead is sampled with address k. Back-to-back reads are supported at one coefficient per cycle.
- DataOutColor, DataOutLast and DataOutNonZero are combinational from ReadBank. They change on the edge after a release.
- DataOut for k=63 is still delivered the cycle after the release, from the old bank. The output mux select and the read-bank half select are registered together.
- Reset may assert mid-block; all pointers and flags return to reset values asynchronously.

## Test plan
- Natural ramp: pair w carries A=2w, B=2w+1, commit colour 1, read k=0..63 → DataOut = 0,1,8,16,9,2,3,10,…,63 (ZZ order), one per cycle, 1-cycle latency; DataOutColor=1.
- Sparse block: only A at w=28 non-zero (natural 56), commit → DataOutLast=35, DataOutNonZero=1. All-zero block → Last=0, NonZero=0.
- Four commits with colours 0..3 and no reads → DataInIdle=0, state S_FULL. A fifth block write and DataInEnd are ignored. After one release, DataInIdle=1 and bank 0 is overwritten next.
- Commit and release in the same cycle at count 2 → count stays 2, ReadBank and WriteBank both advance, DataOutEnable stays 1.
- DataInit asserted with 3 blocks committed and reads in progress → one cycle with DataInIdle=0 (S_INIT), then DataOutEnable=0, DataInIdle=1, next block lands in bank 0.
- Async reset mid-write → all outputs at reset values immediately. The next full block reads back correctly.

Source files
------------

// File: rtl/aq_ejpeg_zigzag.sv
// Zigzag scan buffer: quantizer writes 8x8 blocks in raster order as coefficient pairs,
// encoder reads one coefficient per cycle in zigzag order. Four banks, per-block EOB tracking.
module aq_ejpeg_zigzag (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataInit,
  input  logic        DataInEnable,
  input  logic [4:0]  DataInAddress,
  input  logic [15:0] DataInA,
  input  logic [15:0] DataInB,
  input  logic [2:0]  DataInColor,
  input  logic        DataInEnd,
  output logic        DataInIdle,
  output logic        DataOutEnable,
  input  logic        DataOutRead,
  input  logic [5:0]  DataOutAddress,
  output logic [15:0] DataOut,
  output logic [2:0]  DataOutColor,
  output logic [5:0]  DataOutLast,
  output logic        DataOutNonZero
);

  typedef enum logic [1:0] {StIdle, StValid, StFull, StInit} state_e;

  // Zigzag index -> natural raster index.
  localparam logic [5:0] ZzLut [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Natural raster index -> zigzag index.
  localparam logic [5:0] IzzLut [64] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  state_e      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wb_q, wb_d;
  logic [1:0]  rb_q, rb_d;
  logic [5:0]  last_q, last_d;
  logic        nz_q, nz_d;
  logic [2:0]  bank_color_q [4];
  logic [2:0]  bank_color_d [4];
  logic [5:0]  bank_last_q [4];
  logic [5:0]  bank_last_d [4];
  logic        bank_nz_q [4];
  logic        bank_nz_d [4];
  logic [31:0] rd_word_q, rd_word_d;
  logic        rd_half_q, rd_half_d;
  logic [31:0] mem_q [128];

  logic        wr_en, commit, rel_blk;
  logic [5:0]  izz_a, izz_b, rd_nat;
  logic [5:0]  merged_last;
  logic        merged_nz;

  assign DataInIdle    = (state_q != StFull) && (state_q != StInit);
  assign DataOutEnable = (state_q == StValid) || (state_q == StFull);

  // DataInit wins over every write-side and read-side event in its cycle.
  assign wr_en   = DataInEnable && DataInIdle && !DataInit;
  assign commit  = DataInEnd && DataInIdle && !DataInit;
  assign rel_blk = DataOutRead && (DataOutAddress == 6'd63) && DataOutEnable && !DataInit;

  assign izz_a  = IzzLut[{DataInAddress, 1'b0}];
  assign izz_b  = IzzLut[{DataInAddress, 1'b1}];
  assign rd_nat = ZzLut[DataOutAddress];

  always_comb begin
    merged_last = last_q;
    merged_nz   = nz_q;
    if (wr_en && (DataInA != 16'd0)) begin
      merged_nz = 1'b1;
      if (izz_a > merged_last) merged_last = izz_a;
    end
    if (wr_en && (DataInB != 16'd0)) begin
      merged_nz = 1'b1;
      if (izz_b > merged_last) merged_last = izz_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    last_d      = merged_last;
    nz_d        = merged_nz;
    bank_color_d = bank_color_q;
    bank_last_d  = bank_last_q;
    bank_nz_d    = bank_nz_q;

    if (commit) begin
      bank_color_d[wb_q] = DataInColor;
      bank_last_d[wb_q]  = merged_last;
      bank_nz_d[wb_q]    = merged_nz;
      wb_d               = wb_q + 2'd1;
      last_d             = 6'd0;
      nz_d               = 1'b0;
    end
    if (rel_blk) rb_d = rb_q + 2'd1;

    if (state_q == StInit) begin
      count_d = 3'd0;
      wb_d    = 2'd0;
      rb_d    = 2'd0;
      last_d  = 6'd0;
      nz_d    = 1'b0;
      state_d = StIdle;
    end else begin
      count_d = count_q + {2'b00, commit} - {2'b00, rel_blk};
      if (count_d == 3'd0)      state_d = StIdle;
      else if (count_d == 3'd4) state_d = StFull;
      else                      state_d = StValid;
    end

    if (DataInit) state_d = StInit;
  end

  // Word and half select are captured together so the last read of a bank survives its release.
  always_comb begin
    rd_word_d = rd_word_q;
    rd_half_d = rd_half_q;
    if (DataOutRead) begin
      rd_word_d = mem_q[{rb_q, rd_nat[5:1]}];
      rd_half_d = rd_nat[0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wb_q, DataInAddress}] <= {DataInB, DataInA};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= 3'd0;
      wb_q         <= 2'd0;
      rb_q         <= 2'd0;
      last_q       <= 6'd0;
      nz_q         <= 1'b0;
      bank_color_q <= '{default: 3'd0};
      bank_last_q  <= '{default: 6'd0};
      bank_nz_q    <= '{default: 1'b0};
      rd_word_q    <= 32'd0;
      rd_half_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      last_q       <= last_d;
      nz_q         <= nz_d;
      bank_color_q <= bank_color_d;
      bank_last_q  <= bank_last_d;
      bank_nz_q    <= bank_nz_d;
      rd_word_q    <= rd_word_d;
      rd_half_q    <= rd_half_d;
    end
  end

  assign DataOut        = rd_half_q ? rd_word_q[31:16] : rd_word_q[15:0];
  assign DataOutColor   = bank_color_q[rb_q];
  assign DataOutLast    = bank_last_q[rb_q];
  assign DataOutNonZero = bank_nz_q[rb_q];

endmodule

// File: tb/tb_aq_ejpeg_zigzag.sv
// Directed bench for the zigzag scan buffer: raster writes, zigzag reads, bank flow control.
module tb_aq_ejpeg_zigzag;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DataInit = 1'b0;
  logic        DataInEnable = 1'b0;
  logic [4:0]  DataInAddress = '0;
  logic [15:0] DataInA = '0;
  logic [15:0] DataInB = '0;
  logic [2:0]  DataInColor = '0;
  logic        DataInEnd = 1'b0;
  logic        DataInIdle;
  logic        DataOutEnable;
  logic        DataOutRead = 1'b0;
  logic [5:0]  DataOutAddress = '0;
  logic [15:0] DataOut;
  logic [2:0]  DataOutColor;
  logic [5:0]  DataOutLast;
  logic        DataOutNonZero;

  int n_run  = 0;
  int n_fail = 0;

  // Hand-written JPEG zigzag order (natural index at each zigzag position).
  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  aq_ejpeg_zigzag dut (
    .clk            (clk),
    .rst            (rst),
    .DataInit       (DataInit),
    .DataInEnable   (DataInEnable),
    .DataInAddress  (DataInAddress),
    .DataInA        (DataInA),
    .DataInB        (DataInB),
    .DataInColor    (DataInColor),
    .DataInEnd      (DataInEnd),
    .DataInIdle     (DataInIdle),
    .DataOutEnable  (DataOutEnable),
    .DataOutRead    (DataOutRead),
    .DataOutAddress (DataOutAddress),
    .DataOut        (DataOut),
    .DataOutColor   (DataOutColor),
    .DataOutLast    (DataOutLast),
    .DataOutNonZero (DataOutNonZero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind 0 ramp, 1 single A at natural 56, 2 all zero, 3 natural 0 and 7, 4 only natural 63
  function automatic logic [15:0] pat_a(input int kind, input int base, input int w);
    case (kind)
      0:       return 16'(base + 2 * w);
      1:       return (w == 28) ? 16'h7777 : 16'h0000;
      3:       return (w == 0) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pat_b(input int kind, input int base, input int w);
    case (kind)
      0:       return 16'(base + 2 * w + 1);
      3:       return (w == 3) ? 16'hfffb : 16'h0000;
      4:       return (w == 31) ? 16'h0005 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  // The final pair goes out in the same cycle as DataInEnd when do_commit is set.
  task automatic write_block(input int kind, input int base, input int color,
                             input bit do_commit, input bit rel);
    for (int w = 0; w < 32; w++) begin
      DataInEnable  = 1'b1;
      DataInAddress = 5'(w);
      DataInA       = pat_a(kind, base, w);
      DataInB       = pat_b(kind, base, w);
      if (w == 31) begin
        DataInEnd   = do_commit;
        DataInColor = 3'(color);
        if (rel) begin
          DataOutRead    = 1'b1;
          DataOutAddress = 6'd63;
        end
      end
      step();
    end
    DataInEnable = 1'b0;
    DataInEnd    = 1'b0;
    DataOutRead  = 1'b0;
  endtask

  task automatic read_block(input int base, input string tag);
    for (int k = 0; k < 64; k++) begin
      DataOutRead    = 1'b1;
      DataOutAddress = 6'(k);
      step();
      check($sformatf("%s k%0d", tag, k), DataOut, base + zz[k]);
    end
    DataOutRead = 1'b0;
  endtask

  task automatic release_bank();
    DataOutRead    = 1'b1;
    DataOutAddress = 6'd63;
    step();
    DataOutRead = 1'b0;
  endtask

  initial begin
    #2;
    check("rst DataOut", DataOut, 0);
    check("rst Idle", DataInIdle, 1);
    check("rst OutEn", DataOutEnable, 0);
    check("rst Color", DataOutColor, 0);
    check("rst Last", DataOutLast, 0);
    check("rst NonZero", DataOutNonZero, 0);
    #10;
    rst = 1'b1;
    step();

    // Natural ramp
    write_block(0, 0, 1, 1'b1, 1'b0);
    check("ramp OutEn", DataOutEnable, 1);
    check("ramp Color", DataOutColor, 1);
    check("ramp Last", DataOutLast, 63);
    check("ramp NonZero", DataOutNonZero, 1);
    read_block(0, "ramp");
    check("ramp drained OutEn", DataOutEnable, 0);

    // EOB tracking on sparse and empty blocks
    write_block(1, 0, 2, 1'b1, 1'b0);
    check("sparse Last", DataOutLast, 35);
    check("sparse NonZero", DataOutNonZero, 1);
    check("sparse Color", DataOutColor, 2);
    release_bank();
    write_block(2, 0, 3, 1'b1, 1'b0);
    check("zero Last", DataOutLast, 0);
    check("zero NonZero", DataOutNonZero, 0);
    check("zero Color", DataOutColor, 3);
    release_bank();
    write_block(3, 0, 4, 1'b1, 1'b0);
    check("pair Last", DataOutLast, 28);
    check("pair NonZero", DataOutNonZero, 1);
    release_bank();
    check("empty OutEn", DataOutEnable, 0);

    // Fill all four banks, then try a fifth block
    write_block(0, 100, 0, 1'b1, 1'b0);
    write_block(0, 200, 1, 1'b1, 1'b0);
    write_block(0, 300, 2, 1'b1, 1'b0);
    check("three Idle", DataInIdle, 1);
    write_block(0, 400, 3, 1'b1, 1'b0);
    check("full Idle", DataInIdle, 0);
    check("full OutEn", DataOutEnable, 1);
    write_block(0, 500, 5, 1'b1, 1'b0);
    check("fifth ignored Idle", DataInIdle, 0);
    check("fifth Color", DataOutColor, 0);
    read_block(100, "b100");
    check("after release Idle", DataInIdle, 1);
    check("after release Color", DataOutColor, 1);
    read_block(200, "b200");

    // Commit and release together at count 2
    write_block(0, 600, 4, 1'b1, 1'b1);
    check("swap OutEn", DataOutEnable, 1);
    check("swap Idle", DataInIdle, 1);
    check("swap Color", DataOutColor, 3);
    write_block(0, 700, 5, 1'b1, 1'b0);
    check("count3 Idle", DataInIdle, 1);
    write_block(0, 800, 6, 1'b1, 1'b0);
    check("count4 Idle", DataInIdle, 0);
    read_block(400, "b400");
    check("b600 Color", DataOutColor, 4);
    read_block(600, "b600");
    check("b700 Color", DataOutColor, 5);
    read_block(700, "b700");
    check("b800 Color", DataOutColor, 6);
    read_block(800, "b800");
    check("drained OutEn", DataOutEnable, 0);
    check("drained Idle", DataInIdle, 1);

    // DataInit with three blocks committed, a partial block and a read in flight
    write_block(0, 1000, 1, 1'b1, 1'b0);
    write_block(0, 1100, 2, 1'b1, 1'b0);
    write_block(0, 1200, 3, 1'b1, 1'b0);
    write_block(4, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      DataOutRead    = 1'b1;
      DataOutAddress = 6'(k);
      step();
      check($sformatf("pre-init k%0d", k), DataOut, 1000 + zz[k]);
    end
    DataInit       = 1'b1;
    DataOutAddress = 6'd5;
    step();
    DataInit    = 1'b0;
    DataOutRead = 1'b0;
    check("init Idle", DataInIdle, 0);
    check("init OutEn", DataOutEnable, 0);
    step();
    check("post-init Idle", DataInIdle, 1);
    check("post-init OutEn", DataOutEnable, 0);
    write_block(1, 0, 7, 1'b1, 1'b0);
    check("post-init Color", DataOutColor, 7);
    check("post-init Last", DataOutLast, 35);
    check("post-init OutEn2", DataOutEnable, 1);
    DataOutRead    = 1'b1;
    DataOutAddress = 6'd35;
    step();
    check("post-init k35", DataOut, 16'h7777);
    DataOutAddress = 6'd0;
    step();
    check("post-init k0", DataOut, 0);
    DataOutRead = 1'b0;
    release_bank();
    check("post-init drained", DataOutEnable, 0);

    // Asynchronous reset in the middle of a block
    write_block(0, 3000, 5, 1'b1, 1'b0);
    DataOutRead    = 1'b1;
    DataOutAddress = 6'd1;
    step();
    DataOutRead = 1'b0;
    check("pre-reset k1", DataOut, 3001);
    write_block(0, 5000, 0, 1'b0, 1'b0);
    DataInEnable  = 1'b1;
    DataInAddress = 5'd5;
    #2;
    rst = 1'b0;
    #1;
    check("async DataOut", DataOut, 0);
    check("async Idle", DataInIdle, 1);
    check("async OutEn", DataOutEnable, 0);
    check("async Color", DataOutColor, 0);
    check("async Last", DataOutLast, 0);
    check("async NonZero", DataOutNonZero, 0);
    DataInEnable = 1'b0;
    #2;
    rst = 1'b1;
    step();
    write_block(0, 4000, 2, 1'b1, 1'b0);
    check("post-reset Color", DataOutColor, 2);
    check("post-reset Last", DataOutLast, 63);
    check("post-reset OutEn", DataOutEnable, 1);
    read_block(4000, "b4000");
    check("post-reset drained", DataOutEnable, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
